sum_window_acc: RTL and testbench

//   Downstream consumer of the 4-bit adder's 5-bit sum.
//   - Collects WIN consecutive sums and emits one window result: total, max, min and sample count.
//   - Valid/ready handshake on input and output. Holds the result until the consumer accepts it.
//   - Feeds the result-checking/scoreboard side of the add datapath.

---
 rtl/sum_window_acc.sv | 100 ++++++++++
 tb/tb_sum_window_acc.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sum_window_acc.sv
// sum_window_acc: gathers WIN consecutive adder sums into one window result
//   (total, max, min, sample count) and holds it until the consumer accepts it.
// Ports:
//   clk        single clock, posedge
//   rst        synchronous active-high reset
//   in_valid   in_sum valid this cycle
//   in_ready   sample accepted this cycle (only while accumulating)
//   in_sum     sum from adder stage
//   flush      close a partial window now
//   out_valid  window result valid
//   out_ready  consumer accepts result
//   out_total  sum of window samples
//   out_max    largest sample in window
//   out_min    smallest sample in window
//   out_count  samples in window
module sum_window_acc #(
    parameter int SUM_W = 5,
    parameter int WIN   = 4,
    parameter int ACC_W = 7,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [SUM_W-1:0] out_max,
    output logic [SUM_W-1:0] out_min,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc, r_total;
    logic [SUM_W-1:0] r_max, r_min, w_max, w_min, r_out_max, r_out_min;
    logic [CNT_W-1:0] r_cnt, w_cnt, r_count;
    logic             r_valid, w_take, w_close;
    assign in_ready  = (r_state == ACCUM) && !rst;
    assign w_take    = in_valid && in_ready;
    assign out_valid = r_valid;
    assign out_total = r_total;
    assign out_max   = r_out_max;
    assign out_min   = r_out_min;
    assign out_count = r_count;
    // Running values including the sample accepted this cycle, so a closing
    // window captures its final sample without an extra cycle.
    always_comb begin
        w_acc       = r_acc + (w_take ? ACC_W'(in_sum) : '0);
        w_max       = (w_take && in_sum > r_max) ? in_sum : r_max;
        w_min       = (w_take && in_sum < r_min) ? in_sum : r_min;
        w_cnt       = r_cnt + CNT_W'(w_take);
        w_close     = (w_take && r_cnt == CNT_W'(WIN - 1)) ||
                      (flush && r_state == ACCUM && (r_cnt != '0 || w_take));
        w_state_nxt = r_state;
        if (r_state == ACCUM && w_close)
            w_state_nxt = HOLD;
        else if (r_state == HOLD && out_ready)
            w_state_nxt = ACCUM;
    end
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ACCUM;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_max     <= '0;
            r_min     <= '1;
            r_valid   <= 1'b0;
            r_total   <= '0;
            r_out_max <= '0;
            r_out_min <= '0;
            r_count   <= '0;
        end else if (w_close) begin
            r_total   <= w_acc;
            r_out_max <= w_max;
            r_out_min <= w_min;
            r_count   <= w_cnt;
            r_valid   <= 1'b1;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_max     <= '0;
            r_min     <= '1;
        end else begin
            r_acc <= w_acc;
            r_cnt <= w_cnt;
            r_max <= w_max;
            r_min <= w_min;
            // Result fields are kept after the handshake; only valid drops.
            if (r_state == HOLD && out_ready)
                r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sum_window_acc.sv
// tb_sum_window_acc: directed and randomized checks of sum_window_acc against a window-queue model.
module tb_sum_window_acc;
    localparam int WIN = 4;
    logic       clk = 0;
    logic       rst, in_valid, flush, out_ready;
    logic [4:0] in_sum;
    logic       in_ready, out_valid;
    logic [6:0] out_total;
    logic [4:0] out_max, out_min;
    logic [2:0] out_count;
    int checks = 0, failures = 0;

    sum_window_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
        .out_max(out_max), .out_min(out_min), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a window is the list of accepted samples; a result is derived from it.
    int  win_q[$];
    bit  m_hold, started;
    int  e_valid, e_total, e_max, e_min, e_count;

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            win_q.delete();
            m_hold = 0;
            {e_valid, e_total, e_max, e_min, e_count} = '0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold  = 0;
                e_valid = 0;
            end
        end else begin
            if (in_valid) win_q.push_back(int'(in_sum));
            if (win_q.size() == WIN || (flush && win_q.size() > 0)) begin
                e_total = 0; e_max = 0; e_min = 31;
                foreach (win_q[i]) begin
                    e_total += win_q[i];
                    if (win_q[i] > e_max) e_max = win_q[i];
                    if (win_q[i] < e_min) e_min = win_q[i];
                end
                e_count = win_q.size();
                e_valid = 1;
                m_hold  = 1;
                win_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", int'(in_ready), int'(!m_hold && !rst));
            chk("out_valid", int'(out_valid), e_valid);
            chk("out_total", int'(out_total), e_total);
            chk("out_max", int'(out_max), e_max);
            chk("out_min", int'(out_min), e_min);
            chk("out_count", int'(out_count), e_count);
        end
    end

    task automatic cyc(input bit v, input int s, input bit f, input bit ordy, input bit r);
        in_valid = v; in_sum = 5'(s); flush = f; out_ready = ordy; rst = r;
        @(posedge clk); #1;
    endtask

    task automatic pin(input string tag, input int v, input int t, input int mx, input int mn, input int c);
        chk({tag, "_valid"}, int'(out_valid), v);
        chk({tag, "_total"}, int'(out_total), t);
        chk({tag, "_max"}, int'(out_max), mx);
        chk({tag, "_min"}, int'(out_min), mn);
        chk({tag, "_count"}, int'(out_count), c);
    endtask

    initial begin
        int s1[4] = '{8, 9, 15, 26};
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        pin("reset", 0, 0, 0, 0, 0);
        chk("reset_in_ready_low", int'(in_ready), 0);
        cyc(0, 0, 0, 1, 0);
        chk("reset_in_ready_after", int'(in_ready), 1);
        // 1: back-to-back window
        foreach (s1[i]) cyc(1, s1[i], 0, 1, 0);
        pin("t1", 1, 58, 26, 8, 4);
        chk("t1_in_ready", int'(in_ready), 0);
        cyc(0, 0, 0, 1, 0);
        chk("t1_drop_valid", int'(out_valid), 0);
        chk("t1_keep_total", int'(out_total), 58);
        // 2: back-pressure
        foreach (s1[i]) cyc(1, s1[i], 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0);
            pin("t2_hold", 1, 58, 26, 8, 4);
            chk("t2_in_ready", int'(in_ready), 0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("t2_in_ready_after", int'(in_ready), 1);
        // 3: flush a partial window, then an empty flush
        cyc(1, 10, 0, 0, 0);
        cyc(1, 20, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        pin("t3", 1, 30, 20, 10, 2);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("t3_empty_flush", int'(out_valid), 0);
        // 4: maximum samples, final sample coincides with flush
        for (int k = 0; k < 3; k++) cyc(1, 31, 0, 1, 0);
        cyc(1, 31, 1, 1, 0);
        pin("t4", 1, 124, 31, 31, 4);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t4_single_result", int'(out_valid), 0);
        // 5: reset mid-window discards it
        cyc(1, 5, 0, 1, 0);
        cyc(1, 6, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("t5_no_result", int'(out_valid), 0);
        for (int k = 1; k <= 4; k++) cyc(1, k, 0, 1, 0);
        pin("t5", 1, 10, 4, 1, 4);
        cyc(0, 0, 0, 1, 0);
        // 6: sample offered during HOLD waits for the handshake
        for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        pin("t6_hold", 1, 4, 1, 1, 4);
        cyc(1, 7, 0, 1, 0);
        cyc(1, 7, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        pin("t6", 1, 7, 7, 7, 1);
        cyc(0, 0, 0, 1, 0);
        // randomized traffic against the model
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
